counter_arb_ctrl: RTL and testbench

COUNTER_ARB_CTRL -- requirements
Module: counter_arb_ctrl

---
 rtl/counter_arb_ctrl.sv | 160 ++++++++++++++++
 tb/tb_counter_arb_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_arb_ctrl.sv
// Two-requester controller that sequences runs of a shared external 4-bit counter.
// Define COUNTER_ARB_CTRL_RR_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module counter_arb_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic [3:0] len0,
    input  logic       req1,
    input  logic [3:0] len1,
    input  logic [3:0] cnt_count,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       cnt_load,
    output logic [3:0] cnt_load_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e     state_q;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       done0_q;
    logic       done1_q;
    logic       busy_q;
    logic [3:0] len_q;
    logic       win_valid_s;
    logic       win1_s;

`ifdef COUNTER_ARB_CTRL_RR_EN
    logic       last_q;

    // Round-robin winner selection: on a tie the requester not granted last wins.
    always_comb begin
        win_valid_s = req0 | req1;
        if (req0 && req1) begin
            win1_s = ~last_q;
        end else begin
            win1_s = req1;
        end
    end
`else
    // Fixed-priority winner selection: req0 always beats req1.
    always_comb begin
        win_valid_s = req0 | req1;
        win1_s      = req1 & ~req0;
    end
`endif

    // Run-sequencing FSM with registered grant, done and busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            len_q   <= 4'd0;
`ifdef COUNTER_ARB_CTRL_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        state_q <= ST_START;
                        gnt0_q  <= ~win1_s;
                        gnt1_q  <= win1_s;
                        busy_q  <= 1'b1;
                        len_q   <= win1_s ? len1 : len0;
`ifdef COUNTER_ARB_CTRL_RR_EN
                        last_q  <= win1_s;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                end
                ST_RUN: begin
                    // The counter freezes on the matching value, so len=15 never wraps.
                    if (cnt_count == len_q) begin
                        state_q <= ST_DONE;
                        done0_q <= gnt0_q;
                        done1_q <= gnt1_q;
                    end else begin
                        state_q <= ST_RUN;
                    end
                    busy_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Counter control: hold by reloading the current value, clear in START, count in RUN.
    always_comb begin
        cnt_load      = 1'b1;
        cnt_load_data = cnt_count;
        case (state_q)
            ST_IDLE: begin
                cnt_load      = 1'b1;
                cnt_load_data = cnt_count;
            end
            ST_START: begin
                cnt_load      = 1'b1;
                cnt_load_data = 4'd0;
            end
            ST_RUN: begin
                if (cnt_count == len_q) begin
                    cnt_load = 1'b1;
                end else begin
                    cnt_load = 1'b0;
                end
                cnt_load_data = cnt_count;
            end
            ST_DONE: begin
                cnt_load      = 1'b1;
                cnt_load_data = cnt_count;
            end
            default: begin
                cnt_load      = 1'b1;
                cnt_load_data = cnt_count;
            end
        endcase
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Self-checking bench for counter_arb_ctrl: directed scenarios then random traffic against a
// run-level reference model; includes a behavioural shared counter driven by the DUT.
module tb_counter_arb_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0;
    logic       req1;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [3:0] cnt_count;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       busy;
    logic       cnt_load;
    logic [3:0] cnt_load_data;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a run is "active" for len+3 cycles after a grant; m_k is the cycle index.
    bit m_active;
    int m_k;
    int m_who;
    int m_len;
    int m_held;
    int m_last;

    always #5 clk = ~clk;

    // Shared 4-bit counter, reset by the same reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      cnt_count <= 4'd0;
        else if (cnt_load) cnt_count <= cnt_load_data;
        else               cnt_count <= cnt_count + 4'd1;
    end

    counter_arb_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0          (req0),
        .len0          (len0),
        .req1          (req1),
        .len1          (len1),
        .cnt_count     (cnt_count),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .done0         (done0),
        .done1         (done1),
        .busy          (busy),
        .cnt_load      (cnt_load),
        .cnt_load_data (cnt_load_data)
    );

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_who    = 0;
        m_len    = 0;
        m_held   = 0;
        m_last   = 1;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        int w;
        if (m_active) begin
            if (m_k == m_len + 2) begin
                m_active = 1'b0;
                m_held   = m_len;
            end else begin
                m_k = m_k + 1;
            end
        end else if (req0 || req1) begin
`ifdef COUNTER_ARB_CTRL_RR_EN
            if (req0 && req1) w = (m_last == 1) ? 0 : 1;
            else              w = req1 ? 1 : 0;
`else
            w = req0 ? 0 : 1;
`endif
            m_active = 1'b1;
            m_k      = 0;
            m_who    = w;
            m_len    = (w == 1) ? int'(len1) : int'(len0);
            m_last   = w;
        end
    endtask

    // Expected {gnt0,gnt1,done0,done1,busy,count}.
    function automatic logic [8:0] expected();
        int  c;
        bit  fin;
        if (!m_active) return {5'b00000, 4'(m_held)};
        if (m_k == 0)              c = m_held;
        else if (m_k - 1 > m_len)  c = m_len;
        else                       c = m_k - 1;
        fin = (m_k == m_len + 2);
        return {(m_who == 0), (m_who == 1), (m_who == 0) && fin, (m_who == 1) && fin,
                1'b1, 4'(c)};
    endfunction

    task automatic check(input string tag);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {gnt0, gnt1, done0, done1, busy, cnt_count};
        exp = expected();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed gnt/done/busy/cnt=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic run_to_done(input string tag, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step(tag);
            if (m_active && m_k == m_len + 2) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_timeout: observed no done within %0d cycles, expected done", tag, maxc);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; len0 = 4'd0; len1 = 4'd0;
        model_reset();
        #2;
        check("reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("post_reset");
        step("idle");

        // req0 len 3: count 0..3, done0 at end, counter holds 3
        req0 = 1'b1; len0 = 4'd3;
        run_to_done("len3", 12);
        req0 = 1'b0;
        repeat (3) step("hold3");

        // req0 len 0: single RUN cycle
        req0 = 1'b1; len0 = 4'd0;
        run_to_done("len0", 8);
        req0 = 1'b0;
        step("idle_after_len0");

        // req1 len 15: reaches 15, never wraps
        req1 = 1'b1; len1 = 4'd15;
        run_to_done("len15", 24);
        req1 = 1'b0;
        repeat (3) step("hold15");

        // both held, len 2 each: arbitration order
        req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd2;
        for (int r = 0; r < 4; r++) run_to_done("both_held", 10);
        req0 = 1'b0; req1 = 1'b0;
        step("idle_after_both");

        // len changed mid-run is ignored
        req0 = 1'b1; len0 = 4'd4;
        step("len_chg_a");
        step("len_chg_b");
        len0 = 4'd9;
        run_to_done("len_chg", 14);
        req0 = 1'b0;
        step("hold4");

        // reset during RUN at count 5
        req1 = 1'b1; len1 = 4'd9;
        for (int i = 0; i < 20 && !(m_active && m_k == 6); i++) step("to_count5");
        reset_n = 1'b0;
        req1 = 1'b0;
        model_reset();
        #1;
        check("reset_mid_run");
        @(posedge clk);
        #1;
        check("in_reset");
        reset_n = 1'b1;
        step("after_reset");
        req0 = 1'b1; len0 = 4'd1;
        run_to_done("first_after_reset", 8);
        req0 = 1'b0;
        step("idle_final");

        // random traffic, including mid-run len changes and dropped requests
        for (int i = 0; i < 800; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            len0 = 4'($urandom_range(0, 15));
            len1 = 4'($urandom_range(0, 15));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
